// File: rtl/packet_assembler.sv
// packet_assembler: pairs data/address halves into {data, addr} packets through a small FIFO; PACKET_ASSEMBLER_COUNT_EN adds pkt_count.
module packet_assembler #(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic                     addr_valid,
  output logic                     addr_ready,
  output logic [DATA_W+ADDR_W-1:0] pkt_out,
  output logic                     pkt_valid,
  input  logic                     pkt_ready
`ifdef PACKET_ASSEMBLER_COUNT_EN
  , output logic [15:0]            pkt_count
`endif
);
  localparam int PW = DATA_W + ADDR_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {EMPTY, HAVE_DATA, HAVE_ADDR, HAVE_BOTH} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, data_acc, addr_acc, hold_data, hold_addr, next_data, next_addr;
  always_comb begin
    hold_data = state == HAVE_DATA || state == HAVE_BOTH;
    hold_addr = state == HAVE_ADDR || state == HAVE_BOTH;
    push = state == HAVE_BOTH && count < (AW+1)'(FIFO_DEPTH);
    pop = pkt_valid && pkt_ready;
    data_ready = !reset && (!hold_data || push);
    addr_ready = !reset && (!hold_addr || push);
    data_acc = data_valid && data_ready;
    addr_acc = addr_valid && addr_ready;
    // a pushing pair frees both holders, so accepts in that cycle start the next pair
    next_data = (hold_data && !push) || data_acc;
    next_addr = (hold_addr && !push) || addr_acc;
    state_nx = next_data && next_addr ? HAVE_BOTH : next_data ? HAVE_DATA : next_addr ? HAVE_ADDR : EMPTY;
    pkt_valid = count != '0;
    pkt_out = pkt_valid ? mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      data_q <= '0;
      addr_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (data_acc) data_q <= data_in;
      if (addr_acc) addr_q <= addr_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {data_q, addr_q};
  end
`ifdef PACKET_ASSEMBLER_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) pkt_count <= '0;
    else if (pop) pkt_count <= pkt_count + 16'd1;
  end
`endif
endmodule
